pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, points (1..99) that end a game.
REQ-002 Parameter HOLD_TICKS, default 120, timer_tick count for serve/over hold (1..127; 120 = 2 s at 60 Hz).
REQ-003 clk  in  1  system clock; the single clock domain.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 timer_tick  in  1  one-cycle pulse at frame rate (start of vertical retrace).
REQ-006 start  in  1  level: any player button pressed.
REQ-007 pts_1  in  1  level from the graphics stage: player 1 scored.
REQ-008 pts_2  in  1  level from the graphics stage: player 2 scored.
REQ-009 gra_still  out  1  freeze the ball and recentre it.
REQ-010 score1  out  8  player 1 score, two BCD digits, tens digit in [7:4].
REQ-011 score2  out  8  player 2 score, same format as score1.
REQ-012 game_over  out  1  high in state OVER.
REQ-013 winner  out  2  01 = player 1, 10 = player 2, 00 = none.

Function
REQ-014 FSM states SHALL be NEWGAME, PLAY, NEWBALL and OVER; reset state is NEWGAME.
REQ-015 gra_still SHALL be 1 in every state except PLAY; it is a registered output.
REQ-016 NEWGAME: scores cleared to 0 and winner cleared to 00; start edge (start=1 while prior sample 0) -> PLAY next cycle.
REQ-017 PLAY: pts_1=1 -> score1 +1 BCD, exactly once per entry; pts_2=1 -> score2 +1; both high in the same cycle -> only score1 increments.
REQ-018 PLAY on a score: post-increment score == WIN_SCORE -> OVER, winner set; else -> NEWBALL; timer loaded with HOLD_TICKS in both cases.
REQ-019 pts inputs SHALL be ignored outside PLAY, so a held pts level cannot double-count.
REQ-020 Timer: 7-bit down-counter that decrements on timer_tick when nonzero and holds at 0; expired means value 0.
REQ-021 NEWBALL: timer expired AND start edge -> PLAY.
REQ-022 OVER: timer expired -> NEWGAME; scores remain visible until NEWGAME is entered.
REQ-023 BCD increment: units digit 9 -> 0 with tens +1; score 99 SHALL saturate at 99.
REQ-024 start is sampled in every state, so the edge detector is primed before any transition.
REQ-025 All outputs are registered; latency from pts to score/gra_still is 1 cycle.

Reset
REQ-026 Asserting reset at any time, including mid-hold, SHALL force: state NEWGAME, gra_still=1, score1=score2=8'h00, game_over=0, winner=00, timer=0, start history=1 (a held button does not start a game).

Configuration
REQ-027 Macro PONG_AUTO_SERVE_EN defined: NEWBALL -> PLAY on timer expiry alone, without start.
REQ-028 Macro undefined: a start edge after expiry is required (REQ-021); all other behaviour is identical.

Structure
REQ-029 Shared package pong_pkg SHALL hold the state typedef, the BCD score typedef (8-bit) and the winner encodings.
REQ-030 Sub-module pong_bcd_counter SHALL provide a 2-digit BCD counter with clr and inc inputs, saturating at 99; it is instantiated twice.

Verification
REQ-031 reset, then start pulse -> PLAY after 1 cycle, gra_still=0.
REQ-032 PLAY, pts_1 held 50 cycles -> score1=01 exactly, NEWBALL, gra_still=1; after 120 ticks plus a start edge -> PLAY (no macro); with PONG_AUTO_SERVE_EN, PLAY on the 120th tick.
REQ-033 pts_1 and pts_2 asserted in the same cycle -> score1=01, score2=00.
REQ-034 score2=06, pts_2 -> score2=07, game_over=1, winner=10; 120 ticks -> NEWGAME, scores 00.
REQ-035 WIN_SCORE=99, score1 driven 09 -> 10 and 98 -> 99 -> stays 99 (BCD carry and saturation).
REQ-036 reset asserted mid-NEWBALL with 60 ticks remaining -> all outputs at reset values asynchronously; start held through reset release does not start a game.

Source files
------------

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong game controller:
//   - state_t / ST_*   : controller state encoding (NEWGAME, PLAY, NEWBALL, OVER)
//   - score_t          : two-digit packed BCD score, tens digit in [7:4]
//   - WINNER_*         : encodings of the winner output
//   - bcd_inc()        : saturating (at 99) BCD increment
//   - to_bcd()         : integer (0..99) to packed BCD, used for WIN_SCORE
// -----------------------------------------------------------------------------
package pong_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_NEWGAME = 2'd0;
  localparam state_t ST_PLAY    = 2'd1;
  localparam state_t ST_NEWBALL = 2'd2;
  localparam state_t ST_OVER    = 2'd3;

  typedef logic [7:0] score_t;

  localparam score_t SCORE_MAX = 8'h99;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Units digit wraps 9 -> 0 with a carry into the tens digit; 99 holds.
  function automatic score_t bcd_inc(input score_t v);
    score_t r;
    if (v == SCORE_MAX) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic score_t to_bcd(input int unsigned n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

endpackage

// File: rtl/pong_bcd_counter.sv
// -----------------------------------------------------------------------------
// pong_bcd_counter
// Two-digit BCD score counter, saturating at 99. Clear wins over increment.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset (value -> 00)
//   clr_i    in   synchronous clear to 00
//   inc_i    in   increment by one (BCD) this cycle
//   value_o  out  current score, tens digit in [7:4]
// -----------------------------------------------------------------------------
module pong_bcd_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] value_o
);

  score_t value_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= 8'h00;
    end else if (clr_i) begin
      value_q <= 8'h00;
    end else if (inc_i) begin
      value_q <= bcd_inc(value_q);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
// Game-flow controller for a two-player pong: keeps the BCD scores, freezes
// the ball between rallies, and holds the serve / game-over screens for
// HOLD_TICKS frame ticks.
// Parameters:
//   WIN_SCORE   points (1..99) that end a game
//   HOLD_TICKS  frame ticks (1..127) of serve / game-over hold
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   timer_tick  in   one-cycle pulse per frame
//   start       in   level, any player button pressed
//   pts_1       in   level, player 1 scored
//   pts_2       in   level, player 2 scored
//   gra_still   out  freeze and recentre the ball (high outside PLAY)
//   score1      out  player 1 score, two BCD digits
//   score2      out  player 2 score, two BCD digits
//   game_over   out  high in OVER
//   winner      out  01 player 1, 10 player 2, 00 none
// Configuration macro:
//   PONG_AUTO_SERVE_EN  defined: a new ball is served as soon as the hold
//                       timer expires; undefined: a start edge is also needed.
// All outputs are registered.
// -----------------------------------------------------------------------------
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE  = 7,
  parameter int HOLD_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       timer_tick,
  input  logic       start,
  input  logic       pts_1,
  input  logic       pts_2,
  output logic       gra_still,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam score_t     WIN_BCD   = to_bcd(WIN_SCORE);
  localparam logic [6:0] HOLD_LOAD = 7'(HOLD_TICKS);

  state_t     state_q, state_d;
  logic [6:0] timer_q, timer_d;
  logic [1:0] winner_q, winner_d;
  logic       start_q;
  logic       game_over_q;
  logic       gra_still_q;

  logic       inc1, inc2, clr;
  logic       start_edge, timer_expired, serve_ok;
  score_t     score1_w, score2_w;

  assign start_edge    = start & ~start_q;
  assign timer_expired = (timer_q == 7'd0);

`ifdef PONG_AUTO_SERVE_EN
  assign serve_ok = timer_expired;
`else
  assign serve_ok = timer_expired & start_edge;
`endif

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    inc1     = 1'b0;
    inc2     = 1'b0;
    timer_d  = (timer_tick && !timer_expired) ? timer_q - 7'd1 : timer_q;

    case (state_q)
      ST_NEWGAME: begin
        if (start_edge) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // Player 1 has priority when both report a point in the same cycle.
        // Leaving PLAY on the same edge makes each point count exactly once.
        if (pts_1) begin
          inc1    = 1'b1;
          timer_d = HOLD_LOAD;
          if (bcd_inc(score1_w) == WIN_BCD) begin
            state_d  = ST_OVER;
            winner_d = WINNER_P1;
          end else begin
            state_d = ST_NEWBALL;
          end
        end else if (pts_2) begin
          inc2    = 1'b1;
          timer_d = HOLD_LOAD;
          if (bcd_inc(score2_w) == WIN_BCD) begin
            state_d  = ST_OVER;
            winner_d = WINNER_P2;
          end else begin
            state_d = ST_NEWBALL;
          end
        end
      end
      ST_NEWBALL: begin
        if (serve_ok) state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (timer_expired) state_d = ST_NEWGAME;
      end
      default: state_d = ST_NEWGAME;
    endcase

    // Clearing on the way into NEWGAME keeps the final scores on screen for
    // the whole OVER hold and shows 00 from the first NEWGAME cycle.
    clr = (state_d == ST_NEWGAME);
    if (clr) winner_d = WINNER_NONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_NEWGAME;
      timer_q     <= 7'd0;
      winner_q    <= WINNER_NONE;
      // A button held through reset must not look like a fresh press.
      start_q     <= 1'b1;
      game_over_q <= 1'b0;
      gra_still_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      winner_q    <= winner_d;
      start_q     <= start;
      game_over_q <= (state_d == ST_OVER);
      gra_still_q <= (state_d != ST_PLAY);
    end
  end

  pong_bcd_counter u_score1 (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clr),
    .inc_i   (inc1),
    .value_o (score1_w)
  );

  pong_bcd_counter u_score2 (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clr),
    .inc_i   (inc2),
    .value_o (score2_w)
  );

  assign gra_still = gra_still_q;
  assign score1    = score1_w;
  assign score2    = score2_w;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
// Directed self-checking bench for pong_game_ctrl. A default instance walks a
// full game; a WIN_SCORE=99 / HOLD_TICKS=1 instance covers BCD carry and the
// 99 end score; a bare pong_bcd_counter covers saturation under continuous
// increment. Expected outputs are queued when stimulus is applied and popped
// and compared after the DUT clock edge.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

  localparam int HOLD = 120;

  logic clk = 1'b0;
  logic rst;

  // default instance
  logic       tick, start, p1, p2;
  logic       gs;
  logic [7:0] s1, s2;
  logic       go;
  logic [1:0] win;

  // WIN_SCORE=99 instance
  logic       tick9, start9, p19, p29;
  logic       gs9;
  logic [7:0] s19, s29;
  logic       go9;
  logic [1:0] win9;

  // stand-alone BCD counter
  logic       cclr, cinc;
  logic [7:0] cval;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    int         unit;
    logic [7:0] s1;
    logic [7:0] s2;
    logic       gs;
    logic       go;
    logic [1:0] w;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk        (clk),
    .reset      (rst),
    .timer_tick (tick),
    .start      (start),
    .pts_1      (p1),
    .pts_2      (p2),
    .gra_still  (gs),
    .score1     (s1),
    .score2     (s2),
    .game_over  (go),
    .winner     (win)
  );

  pong_game_ctrl #(.WIN_SCORE(99), .HOLD_TICKS(1)) dut99 (
    .clk        (clk),
    .reset      (rst),
    .timer_tick (tick9),
    .start      (start9),
    .pts_1      (p19),
    .pts_2      (p29),
    .gra_still  (gs9),
    .score1     (s19),
    .score2     (s29),
    .game_over  (go9),
    .winner     (win9)
  );

  pong_bcd_counter u_cnt (
    .clk     (clk),
    .reset   (rst),
    .clr_i   (cclr),
    .inc_i   (cinc),
    .value_o (cval)
  );

  // Integer score to packed BCD, the form the score outputs use.
  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int unit, input int e1, input int e2,
                      input logic egs, input logic ego, input logic [1:0] ew);
    exp_t e;
    e.tag  = tag;
    e.unit = unit;
    e.s1   = bcd(e1);
    e.s2   = bcd(e2);
    e.gs   = egs;
    e.go   = ego;
    e.w    = ew;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [7:0] o1, o2;
    logic       ogs, ogo;
    logic [1:0] ow;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    if (e.unit == 0) begin
      o1 = s1;  o2 = s2;  ogs = gs;  ogo = go;  ow = win;
    end else begin
      o1 = s19; o2 = s29; ogs = gs9; ogo = go9; ow = win9;
    end
    check({e.tag, ".score1"},    o1,          e.s1);
    check({e.tag, ".score2"},    o2,          e.s2);
    check({e.tag, ".gra_still"}, {7'd0, ogs}, {7'd0, e.gs});
    check({e.tag, ".game_over"}, {7'd0, ogo}, {7'd0, e.go});
    check({e.tag, ".winner"},    {6'd0, ow},  {6'd0, e.w});
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  // Expire the serve hold and press start (the press is harmless when the
  // auto-serve build has already resumed play).
  task automatic serve();
    tick_n(HOLD);
    start_pulse();
  endtask

  initial begin
    rst = 1'b1;
    tick = 1'b0; start = 1'b0; p1 = 1'b0; p2 = 1'b0;
    tick9 = 1'b0; start9 = 1'b0; p19 = 1'b0; p29 = 1'b0;
    cclr = 1'b0; cinc = 1'b0;

    // ---------------- reset state ----------------
    push("reset", 0, 0, 0, 1'b1, 1'b0, 2'b00);
    repeat (3) step();
    pop_check();
    rst = 1'b0;
    push("idle_newgame", 0, 0, 0, 1'b1, 1'b0, 2'b00);
    step();
    step();
    pop_check();

    // ---------------- start -> PLAY after one cycle ----------------
    start = 1'b1;
    push("start_play", 0, 0, 0, 1'b0, 1'b0, 2'b00);
    step();
    pop_check();
    start = 1'b0;
    step();

    // ---------------- held pts_1 counts once ----------------
    p1 = 1'b1;
    push("pts1_held", 0, 1, 0, 1'b1, 1'b0, 2'b00);
    repeat (50) step();
    pop_check();
    p1 = 1'b0;

    // start before the hold expires must not serve
    push("early_start", 0, 1, 0, 1'b1, 1'b0, 2'b00);
    start_pulse();
    pop_check();

    push("hold_119", 0, 1, 0, 1'b1, 1'b0, 2'b00);
    tick_n(HOLD - 1);
    pop_check();
`ifdef PONG_AUTO_SERVE_EN
    push("hold_120_auto", 0, 1, 0, 1'b0, 1'b0, 2'b00);
`else
    push("hold_120_wait", 0, 1, 0, 1'b1, 1'b0, 2'b00);
`endif
    tick_n(1);
    pop_check();
    push("serve", 0, 1, 0, 1'b0, 1'b0, 2'b00);
    start_pulse();
    pop_check();

    // ---------------- simultaneous points: player 1 wins the tie ----------------
    p1 = 1'b1;
    p2 = 1'b1;
    push("both_pts", 0, 2, 0, 1'b1, 1'b0, 2'b00);
    step();
    pop_check();
    p1 = 1'b0;
    p2 = 1'b0;

    // ---------------- player 2 runs up to 06 ----------------
    for (int k = 1; k <= 6; k++) begin
      serve();
      p2 = 1'b1;
      push($sformatf("p2_point%0d", k), 0, 2, k, 1'b1, 1'b0, 2'b00);
      step();
      pop_check();
      p2 = 1'b0;
    end

    // ---------------- 06 -> 07 ends the game ----------------
    serve();
    p2 = 1'b1;
    push("p2_wins", 0, 2, 7, 1'b1, 1'b1, 2'b10);
    step();
    pop_check();
    p2 = 1'b0;

    // points ignored in OVER
    p1 = 1'b1;
    push("over_ignores_pts", 0, 2, 7, 1'b1, 1'b1, 2'b10);
    repeat (3) step();
    pop_check();
    p1 = 1'b0;

    push("over_hold_119", 0, 2, 7, 1'b1, 1'b1, 2'b10);
    tick_n(HOLD - 1);
    pop_check();
    push("over_to_newgame", 0, 0, 0, 1'b1, 1'b0, 2'b00);
    tick_n(1);
    pop_check();

    // ---------------- reset in NEWBALL with 60 ticks left ----------------
    start_pulse();
    p1 = 1'b1;
    push("pre_reset_point", 0, 1, 0, 1'b1, 1'b0, 2'b00);
    step();
    pop_check();
    p1 = 1'b0;
    tick_n(HOLD - 60);
    start = 1'b1;
    #2;
    rst = 1'b1;
    push("async_reset", 0, 0, 0, 1'b1, 1'b0, 2'b00);
    #1;
    pop_check();
    step();
    rst = 1'b0;
    push("held_start_after_reset", 0, 0, 0, 1'b1, 1'b0, 2'b00);
    repeat (4) step();
    pop_check();
    start = 1'b0;
    step();
    start = 1'b1;
    push("fresh_start_after_reset", 0, 0, 0, 1'b0, 1'b0, 2'b00);
    step();
    pop_check();
    start = 1'b0;
    step();

    // ---------------- WIN_SCORE=99: BCD carry and 99 end score ----------------
    start9 = 1'b1;
    step();
    start9 = 1'b0;
    step();
    for (int k = 1; k <= 99; k++) begin
      p19 = 1'b1;
      if (k == 9 || k == 10 || k == 98)
        push($sformatf("w99_point%0d", k), 1, k, 0, 1'b1, 1'b0, 2'b00);
      else if (k == 99)
        push("w99_final", 1, 99, 0, 1'b1, 1'b1, 2'b01);
      step();
      if (k == 9 || k == 10 || k >= 98) pop_check();
      p19 = 1'b0;
      if (k < 99) begin
        tick9 = 1'b1;
        step();
        tick9 = 1'b0;
        start9 = 1'b1;
        step();
        start9 = 1'b0;
      end
    end
    p19 = 1'b1;
    push("w99_stays_99", 1, 99, 0, 1'b1, 1'b1, 2'b01);
    repeat (5) step();
    pop_check();
    p19 = 1'b0;

    // ---------------- stand-alone counter saturation ----------------
    cclr = 1'b1;
    step();
    cclr = 1'b0;
    cinc = 1'b1;
    for (int i = 1; i <= 110; i++) begin
      step();
      if (i == 10)  check("cnt_carry_10", cval, bcd(10));
      if (i == 99)  check("cnt_reach_99", cval, bcd(99));
      if (i == 110) check("cnt_sat_99",   cval, bcd(99));
    end
    cclr = 1'b1;
    step();
    check("cnt_clr_over_inc", cval, bcd(0));
    cclr = 1'b0;
    cinc = 1'b0;

    checks++;
    assert (sb.size() == 0)
    else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
